// File: rtl/motor_axil_if.sv
// AXI4-Lite bus bundle for the motor PWM slave.
// Carries the five AXI4-Lite channels (AW, W, B, AR, R).
// master modport: drives addresses, write data, valids and response readies.
// slave modport : drives address/data readies and the B/R response channels.
interface motor_axil_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/motor_axil_slave.sv
// AXI4-Lite slave with a PWM motor driver behind a four-register map.
// Ports:
//   ACLK, ARESETN  sole clock, asynchronous active-low reset
//   s_axi          AXI4-Lite slave bus (motor_axil_if.slave)
//   pwm_out        registered PWM drive, high while counter < active duty
//   dir_out        motor direction, CTRL.bit1
// Register map (word address = AxADDR[3:2]):
//   0x0 CTRL   bit0 enable, bit1 dir
//   0x4 PERIOD bits[15:0]
//   0x8 DUTY   bits[15:0]
//   0xC STATUS bits[15:0] counter, bit16 running (read-only)
// Build option: define MOTOR_AXIL_WSTRB_EN to let WSTRB gate byte lanes;
// otherwise every register write is a full-word write.
//
// state  | meaning
// W_IDLE | waiting for AWVALID and WVALID together; pulses AW/WREADY
// W_RESP | write done, BVALID held until BREADY
// R_IDLE | waiting for ARVALID; pulses ARREADY
// R_DATA | RVALID held with stable RDATA until RREADY
module motor_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic          ACLK,
  input  logic          ARESETN,
  motor_axil_if.slave   s_axi,
  output logic          pwm_out,
  output logic          dir_out
);
  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic awready_q, awready_d, bvalid_q, bvalid_d, arready_q, arready_d;
  logic rvalid_q, rvalid_d, reg_we;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d, rd_word;
  logic ctrl_en_q, ctrl_en_d, ctrl_dir_q, ctrl_dir_d, en_prev_q, en_prev_d;
  logic pwm_q, pwm_d, first_cycle, running;
  logic [15:0] period_q, period_d, duty_q, duty_d, cnt_q, cnt_d;
  logic [15:0] act_period_q, act_period_d, act_duty_q, act_duty_d;
  logic [15:0] per_cmp, duty_cmp;
  logic [31:0] wr_word;
  logic [3:0]  wstrb_eff;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr, araddr;

  assign awaddr = s_axi.AWADDR;
  assign araddr = s_axi.ARADDR;

`ifdef MOTOR_AXIL_WSTRB_EN
  assign wstrb_eff = s_axi.WSTRB;
`else
  assign wstrb_eff = 4'hF;
  logic unused_strb;
  assign unused_strb = ^s_axi.WSTRB;
`endif

  logic unused_misc;
  assign unused_misc = ^{s_axi.AWPROT, s_axi.ARPROT, awaddr[1:0], araddr[1:0], wr_word[31:16]};

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return res;
  endfunction

  // Write FSM: ready is registered, so the handshake lands one cycle after
  // both valids are seen; the register update happens on that same edge.
  always_comb begin
    w_state_d = w_state_q;
    awready_d = 1'b0;
    bvalid_d  = bvalid_q;
    reg_we    = 1'b0;
    case (w_state_q)
      W_IDLE: if (s_axi.AWVALID && s_axi.WVALID) begin
        if (awready_q) begin
          reg_we    = 1'b1;
          bvalid_d  = 1'b1;
          w_state_d = W_RESP;
        end else begin
          awready_d = 1'b1;
        end
      end
      W_RESP: if (s_axi.BREADY) begin
        bvalid_d  = 1'b0;
        w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    ctrl_en_d  = ctrl_en_q;
    ctrl_dir_d = ctrl_dir_q;
    period_d   = period_q;
    duty_d     = duty_q;
    wr_word    = '0;
    if (reg_we) begin
      case (awaddr[3:2])
        2'd0: begin
          wr_word    = merge({30'd0, ctrl_dir_q, ctrl_en_q}, s_axi.WDATA, wstrb_eff);
          ctrl_en_d  = wr_word[0];
          ctrl_dir_d = wr_word[1];
        end
        2'd1: begin
          wr_word  = merge({16'd0, period_q}, s_axi.WDATA, wstrb_eff);
          period_d = wr_word[15:0];
        end
        2'd2: begin
          wr_word = merge({16'd0, duty_q}, s_axi.WDATA, wstrb_eff);
          duty_d  = wr_word[15:0];
        end
        default: ;
      endcase
    end
  end

  assign running = ctrl_en_q && (period_q != 16'd0);

  always_comb begin
    case (araddr[3:2])
      2'd0:    rd_word = {30'd0, ctrl_dir_q, ctrl_en_q};
      2'd1:    rd_word = {16'd0, period_q};
      2'd2:    rd_word = {16'd0, duty_q};
      default: rd_word = {15'd0, running, cnt_q};
    endcase
  end

  // Read FSM: RDATA is captured from the current register values, so a
  // write landing on the same edge is not visible in this read.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = 1'b0;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: if (s_axi.ARVALID) begin
        if (arready_q) begin
          rdata_d   = rd_word;
          rvalid_d  = 1'b1;
          r_state_d = R_DATA;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: if (s_axi.RREADY) begin
        rvalid_d  = 1'b0;
        r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // PWM: on the first enabled cycle the live PERIOD/DUTY are used directly
  // while they load into the shadows. A zero active period reloads every
  // cycle so a later PERIOD write is picked up without waiting for a wrap.
  assign first_cycle = ctrl_en_q && !en_prev_q;
  assign per_cmp     = first_cycle ? period_q : act_period_q;
  assign duty_cmp    = first_cycle ? duty_q   : act_duty_q;

  always_comb begin
    en_prev_d    = ctrl_en_q;
    cnt_d        = '0;
    pwm_d        = 1'b0;
    act_period_d = act_period_q;
    act_duty_d   = act_duty_q;
    if (ctrl_en_q) begin
      pwm_d = (per_cmp != 16'd0) && (cnt_q < duty_cmp);
      if (per_cmp == 16'd0 || cnt_q >= per_cmp - 16'd1) begin
        cnt_d        = '0;
        act_period_d = period_q;
        act_duty_d   = duty_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
        if (first_cycle) begin
          act_period_d = period_q;
          act_duty_d   = duty_q;
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q    <= W_IDLE;
      r_state_q    <= R_IDLE;
      awready_q    <= 1'b0;
      bvalid_q     <= 1'b0;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      ctrl_en_q    <= 1'b0;
      ctrl_dir_q   <= 1'b0;
      period_q     <= '0;
      duty_q       <= '0;
      act_period_q <= '0;
      act_duty_q   <= '0;
      cnt_q        <= '0;
      pwm_q        <= 1'b0;
      en_prev_q    <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      r_state_q    <= r_state_d;
      awready_q    <= awready_d;
      bvalid_q     <= bvalid_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      ctrl_en_q    <= ctrl_en_d;
      ctrl_dir_q   <= ctrl_dir_d;
      period_q     <= period_d;
      duty_q       <= duty_d;
      act_period_q <= act_period_d;
      act_duty_q   <= act_duty_d;
      cnt_q        <= cnt_d;
      pwm_q        <= pwm_d;
      en_prev_q    <= en_prev_d;
    end
  end

  assign s_axi.AWREADY = awready_q;
  assign s_axi.WREADY  = awready_q;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = 2'b00;
  assign s_axi.ARREADY = arready_q;
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RDATA   = rdata_q;
  assign s_axi.RRESP   = 2'b00;
  assign pwm_out       = pwm_q;
  assign dir_out       = ctrl_dir_q;
endmodule

// File: tb/tb_motor_axil_slave.sv
module tb_motor_axil_slave;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pwm_out, dir_out;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  motor_axil_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

  motor_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .ACLK(clk), .ARESETN(rst_n), .s_axi(bus), .pwm_out(pwm_out), .dir_out(dir_out)
  );

`ifdef MOTOR_AXIL_WSTRB_EN
  localparam logic [31:0] EXP_STRB = 32'h0000_00DD;
`else
  localparam logic [31:0] EXP_STRB = 32'h0000_CCDD;
`endif

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    logic [31:0] mask;
    string       name;
  } vec_t;

  vec_t vecs[16];

  // High-run lengths of pwm_out, sampled on falling clock edges.
  int run_len = 0;
  int runq[$];
  always @(negedge clk) begin
    if (pwm_out) run_len++;
    else if (run_len != 0) begin
      runq.push_back(run_len);
      run_len = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=handshake", nm);
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    @(negedge clk);
    bus.AWADDR = addr; bus.WDATA = data; bus.WSTRB = strb;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.BREADY = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.AWREADY && n < 20);
    if (!bus.AWREADY) timeout("write_accept");
    @(negedge clk);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    n = 0;
    while (!bus.BVALID && n < 20) begin @(negedge clk); n++; end
    if (!bus.BVALID) timeout("write_bvalid");
    else chk("bresp", {30'd0, bus.BRESP}, 32'd0);
    @(negedge clk);
    bus.BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int n;
    data = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.ARADDR = addr; bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.ARREADY && n < 20);
    if (!bus.ARREADY) timeout("read_accept");
    @(negedge clk);
    bus.ARVALID = 1'b0;
    n = 0;
    while (!bus.RVALID && n < 20) begin @(negedge clk); n++; end
    if (!bus.RVALID) timeout("read_rvalid");
    else begin
      data = bus.RDATA;
      chk("rresp", {30'd0, bus.RRESP}, 32'd0);
    end
    @(negedge clk);
    bus.RREADY = 1'b0;
  endtask

  task automatic count_pwm(input int cycles, output int hi);
    hi = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (pwm_out) hi++;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd, rd2;
    int hi, n;
    logic prev;

    vecs[0]  = '{1'b1, 4'h0, 32'h0000_0001, 4'hF, 32'h0, 32'h0, "w_ctrl"};
    vecs[1]  = '{1'b1, 4'h4, 32'h0000_0002, 4'hF, 32'h0, 32'h0, "w_period"};
    vecs[2]  = '{1'b1, 4'h8, 32'h0000_0003, 4'hF, 32'h0, 32'h0, "w_duty"};
    vecs[3]  = '{1'b0, 4'h0, 32'h0, 4'h0, 32'h0000_0001, 32'hFFFF_FFFF, "r_ctrl"};
    vecs[4]  = '{1'b0, 4'h4, 32'h0, 4'h0, 32'h0000_0002, 32'hFFFF_FFFF, "r_period"};
    vecs[5]  = '{1'b0, 4'h8, 32'h0, 4'h0, 32'h0000_0003, 32'hFFFF_FFFF, "r_duty"};
    vecs[6]  = '{1'b0, 4'hC, 32'h0, 4'h0, 32'h0001_0000, 32'hFFFF_0000, "r_status_run"};
    vecs[7]  = '{1'b1, 4'hC, 32'h0000_FFFF, 4'hF, 32'h0, 32'h0, "w_status"};
    vecs[8]  = '{1'b0, 4'h4, 32'h0, 4'h0, 32'h0000_0002, 32'hFFFF_FFFF, "r_period_kept"};
    vecs[9]  = '{1'b1, 4'h0, 32'hFFFF_FFFC, 4'hF, 32'h0, 32'h0, "w_ctrl_off"};
    vecs[10] = '{1'b0, 4'h0, 32'h0, 4'h0, 32'h0000_0000, 32'hFFFF_FFFF, "r_ctrl_off"};
    vecs[11] = '{1'b0, 4'hC, 32'h0, 4'h0, 32'h0000_0000, 32'hFFFF_FFFF, "r_status_idle"};
    vecs[12] = '{1'b1, 4'h4, 32'hAABB_CCDD, 4'h1, 32'h0, 32'h0, "w_period_strb"};
    vecs[13] = '{1'b0, 4'h4, 32'h0, 4'h0, EXP_STRB, 32'hFFFF_FFFF, "r_period_strb"};
    vecs[14] = '{1'b1, 4'h0, 32'hFFFF_FFFF, 4'hF, 32'h0, 32'h0, "w_ctrl_all"};
    vecs[15] = '{1'b0, 4'h0, 32'h0, 4'h0, 32'h0000_0003, 32'hFFFF_FFFF, "r_ctrl_all"};

    bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0;
    bus.WVALID = 1'b0; bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARPROT = '0;
    bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

    wait_cycles(3);
    chk("rst_awready", {31'd0, bus.AWREADY}, 32'd0);
    chk("rst_wready", {31'd0, bus.WREADY}, 32'd0);
    chk("rst_bvalid", {31'd0, bus.BVALID}, 32'd0);
    chk("rst_arready", {31'd0, bus.ARREADY}, 32'd0);
    chk("rst_rvalid", {31'd0, bus.RVALID}, 32'd0);
    chk("rst_rdata", bus.RDATA, 32'd0);
    chk("rst_pwm", {31'd0, pwm_out}, 32'd0);
    chk("rst_dir", {31'd0, dir_out}, 32'd0);
    rst_n = 1'b1;
    wait_cycles(2);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      else begin
        axi_read(vecs[i].addr, rd);
        chk(vecs[i].name, rd & vecs[i].mask, vecs[i].exp & vecs[i].mask);
      end
    end
    axi_write(4'h0, 32'h0, 4'hF);

    // 10-cycle period, 3 high
    axi_write(4'h4, 32'd10, 4'hF);
    axi_write(4'h8, 32'd3, 4'hF);
    axi_write(4'h0, 32'h3, 4'hF);
    chk("dir_set", {31'd0, dir_out}, 32'd1);
    wait_cycles(25);
    count_pwm(30, hi);
    chk("pwm_3_of_10", hi, 32'd9);
    axi_read(4'hC, rd);
    chk("status_running", rd & 32'hFFFF_0000, 32'h0001_0000);

    // DUTY=0 then PERIOD=0
    axi_write(4'h8, 32'd0, 4'hF);
    wait_cycles(15);
    count_pwm(20, hi);
    chk("duty_zero", hi, 32'd0);
    axi_write(4'h4, 32'd0, 4'hF);
    wait_cycles(15);
    count_pwm(20, hi);
    chk("period_zero_pwm", hi, 32'd0);
    axi_read(4'hC, rd);
    chk("period_zero_status", rd, 32'h0000_0000);

    // DUTY>=PERIOD, then clear enable
    axi_write(4'h4, 32'd10, 4'hF);
    axi_write(4'h8, 32'd10, 4'hF);
    wait_cycles(15);
    count_pwm(20, hi);
    chk("duty_ge_period", hi, 32'd20);
    axi_write(4'h0, 32'h0, 4'hF);
    chk("disable_pwm", {31'd0, pwm_out}, 32'd0);
    axi_read(4'hC, rd);
    chk("disable_status", rd, 32'h0);

    // Mid-period DUTY change applies from the next wrap
    axi_write(4'h4, 32'd8, 4'hF);
    axi_write(4'h8, 32'd2, 4'hF);
    axi_write(4'h0, 32'h1, 4'hF);
    wait_cycles(20);
    prev = pwm_out;
    n = 0;
    do begin @(negedge clk); n++; if (!prev && pwm_out) break; prev = pwm_out; end while (n < 40);
    if (n >= 40) timeout("pwm_rise");
    runq.delete();
    axi_write(4'h8, 32'd6, 4'hF);
    wait_cycles(24);
    if (runq.size() < 2) timeout("pwm_runs");
    else begin
      chk("run_before_wrap", runq[0], 32'd2);
      chk("run_after_wrap", runq[1], 32'd6);
    end
    axi_write(4'h8, 32'd9, 4'hF);
    wait_cycles(20);
    count_pwm(16, hi);
    chk("duty_9_const", hi, 32'd16);

    // WVALID alone, then AWVALID alone, then both; BREADY held low
    @(negedge clk);
    bus.WDATA = 32'h55; bus.WSTRB = 4'hF; bus.WVALID = 1'b1; bus.BREADY = 1'b0;
    hi = 0;
    repeat (5) begin @(negedge clk); if (bus.WREADY || bus.AWREADY) hi++; end
    chk("wvalid_alone", hi, 32'd0);
    bus.WVALID = 1'b0;
    bus.AWADDR = 4'h4; bus.AWVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("awvalid_alone", {31'd0, bus.AWREADY}, 32'd0);
    end
    bus.WVALID = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.AWREADY && n < 20);
    if (!bus.AWREADY) timeout("aw_w_accept");
    chk("wready_with_aw", {31'd0, bus.WREADY}, 32'd1);
    @(negedge clk);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    chk("awready_pulse", {31'd0, bus.AWREADY}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("bvalid_hold", {31'd0, bus.BVALID}, 32'd1);
      @(negedge clk);
    end
    bus.BREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0;
    chk("bvalid_release", {31'd0, bus.BVALID}, 32'd0);
    axi_read(4'h4, rd);
    chk("period_after_split", rd, 32'h55);

    // Simultaneous read and write of PERIOD returns the old value
    fork
      axi_write(4'h4, 32'h77, 4'hF);
      axi_read(4'h4, rd);
    join
    chk("simul_pre_write", rd, 32'h55);
    axi_read(4'h4, rd);
    chk("simul_post_write", rd, 32'h77);

    // Reset while a read response is pending
    axi_write(4'h0, 32'h0, 4'hF);
    axi_write(4'h4, 32'd4, 4'hF);
    axi_write(4'h8, 32'd4, 4'hF);
    axi_write(4'h0, 32'h3, 4'hF);
    wait_cycles(5);
    chk("pre_rst_pwm", {31'd0, pwm_out}, 32'd1);
    @(negedge clk);
    bus.ARADDR = 4'h8; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.ARREADY && n < 20);
    if (!bus.ARREADY) timeout("pend_read_accept");
    @(negedge clk);
    bus.ARVALID = 1'b0;
    wait_cycles(3);
    chk("pend_rvalid", {31'd0, bus.RVALID}, 32'd1);
    chk("pend_rdata", bus.RDATA, 32'd4);
    rst_n = 1'b0;
    #1;
    chk("async_rvalid", {31'd0, bus.RVALID}, 32'd0);
    chk("async_pwm", {31'd0, pwm_out}, 32'd0);
    chk("async_dir", {31'd0, dir_out}, 32'd0);
    chk("async_rdata", bus.RDATA, 32'd0);
    wait_cycles(3);
    rst_n = 1'b1;
    hi = 0;
    repeat (5) begin @(negedge clk); if (bus.RVALID || bus.BVALID) hi++; end
    chk("no_resp_after_rst", hi, 32'd0);
    axi_read(4'h0, rd);
    chk("post_rst_ctrl", rd, 32'd0);
    axi_read(4'h4, rd);
    chk("post_rst_period", rd, 32'd0);
    axi_read(4'h8, rd);
    chk("post_rst_duty", rd, 32'd0);
    axi_read(4'hC, rd2);
    chk("post_rst_status", rd2, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
